// File: rtl/exe_mem_stage.sv
// exe_mem_stage: EXE->MEM pipeline stage that runs loads/stores over a req/addr_ok/data_ok SRAM bus.
//  Upstream:   exe_valid/exe_allowin handshake, instruction fields exe_*, flush kills the held instruction
//  SRAM:       data_sram_req/wr/wstrb/addr/wdata out, addr_ok/data_ok/rdata in; at most one transaction outstanding
//  Downstream: mem_valid/mem_allowin handshake with registered mem_pc/mem_rd/mem_ref_we/mem_result
//  Hazards:    fwd_* bypass of the finished result, load_stall while a load is still in flight
module exe_mem_stage #(
  parameter logic [31:0] RESET_PC = 32'h1bfffffc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid,
  output logic        exe_allowin,
  input  logic [31:0] exe_pc,
  input  logic [4:0]  exe_rd,
  input  logic        exe_ref_we,
  input  logic [31:0] exe_alu_result,
  input  logic        exe_dram_re,
  input  logic        exe_dram_we,
  input  logic [1:0]  exe_mem_size,
  input  logic        exe_mem_sext,
  input  logic [31:0] exe_dram_wdata,
  input  logic        flush,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        mem_valid,
  input  logic        mem_allowin,
  output logic [31:0] mem_pc,
  output logic [4:0]  mem_rd,
  output logic        mem_ref_we,
  output logic [31:0] mem_result,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_result,
  output logic        load_stall
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;
  logic cancel, is_load, sext, accept, mem_op;
  logic [1:0] size;
  logic [3:0] st_strb;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [31:0] st_data, ld_data;
  // cancel marks a killed transaction whose data_ok is still owed; nothing new may start until it is swallowed
  assign exe_allowin = !rst && !cancel && (state == IDLE || (state == DONE && mem_allowin));
  assign accept = exe_valid && exe_allowin && !flush;
  assign mem_op = exe_dram_re || exe_dram_we;
  assign mem_valid = state == DONE;
  assign load_stall = is_load && (state == REQ || state == WAIT);
  assign fwd_valid = mem_valid && mem_ref_we;
  assign fwd_rd = mem_rd;
  assign fwd_result = mem_result;
  always_comb begin
    st_strb = exe_mem_size[1] ? 4'hf : exe_mem_size[0] ? (exe_alu_result[1] ? 4'hc : 4'h3) : 4'h1 << exe_alu_result[1:0];
    st_data = exe_mem_size[1] ? exe_dram_wdata : exe_mem_size[0] ? {2{exe_dram_wdata[15:0]}} : {4{exe_dram_wdata[7:0]}};
    lb = 8'(data_sram_rdata >> {data_sram_addr[1:0], 3'b000});
    lh = 16'(data_sram_rdata >> {data_sram_addr[1], 4'b0000});
    ld_data = size[1] ? data_sram_rdata : size[0] ? {{16{sext && lh[15]}}, lh} : {{24{sext && lb[7]}}, lb};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cancel <= 1'b0;
      is_load <= 1'b0;
      sext <= 1'b0;
      size <= 2'd0;
      mem_pc <= RESET_PC;
      mem_rd <= 5'd0;
      mem_ref_we <= 1'b0;
      mem_result <= 32'd0;
      data_sram_req <= 1'b0;
      data_sram_wr <= 1'b0;
      data_sram_wstrb <= 4'h0;
      data_sram_addr <= 32'd0;
      data_sram_wdata <= 32'd0;
    end else begin
      if (cancel && data_sram_data_ok) cancel <= 1'b0;
      if (flush) begin
        // a request already accepted by the SRAM still owes a data_ok, unless it arrives right now
        if ((state == REQ && data_sram_addr_ok) || (state == WAIT && !data_sram_data_ok)) cancel <= 1'b1;
        state <= IDLE;
        data_sram_req <= 1'b0;
        mem_pc <= RESET_PC;
      end else if (accept) begin
        state <= mem_op ? REQ : DONE;
        mem_pc <= exe_pc;
        mem_rd <= exe_rd;
        mem_ref_we <= exe_ref_we;
        mem_result <= exe_alu_result;
        size <= exe_mem_size;
        sext <= exe_mem_sext;
        is_load <= exe_dram_re;
        data_sram_req <= mem_op;
        data_sram_wr <= exe_dram_we;
        data_sram_wstrb <= exe_dram_we ? st_strb : 4'h0;
        data_sram_addr <= exe_alu_result;
        data_sram_wdata <= st_data;
      end else if (state == REQ && data_sram_addr_ok) begin
        state <= WAIT;
        data_sram_req <= 1'b0;
      end else if (state == WAIT && data_sram_data_ok) begin
        state <= DONE;
        if (is_load) mem_result <= ld_data;
      end else if (state == DONE && mem_allowin) begin
        state <= IDLE;
        mem_pc <= RESET_PC;
      end
    end
endmodule

// File: tb/tb_exe_mem_stage.sv
// tb_exe_mem_stage: directed vectors, corner sequences and a randomized scoreboard run for exe_mem_stage
module tb_exe_mem_stage;
  logic clk = 1'b0, rst;
  logic exe_valid, exe_allowin, exe_ref_we, exe_dram_re, exe_dram_we, exe_mem_sext, flush;
  logic [31:0] exe_pc, exe_alu_result, exe_dram_wdata;
  logic [4:0] exe_rd;
  logic [1:0] exe_mem_size;
  logic data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [3:0] data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic mem_valid, mem_allowin, mem_ref_we, fwd_valid, load_stall;
  logic [31:0] mem_pc, mem_result, fwd_result;
  logic [4:0] mem_rd, fwd_rd;
  int n_cmp = 0, n_bad = 0;

  exe_mem_stage dut (
    .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_allowin(exe_allowin), .exe_pc(exe_pc), .exe_rd(exe_rd),
    .exe_ref_we(exe_ref_we), .exe_alu_result(exe_alu_result), .exe_dram_re(exe_dram_re), .exe_dram_we(exe_dram_we),
    .exe_mem_size(exe_mem_size), .exe_mem_sext(exe_mem_sext), .exe_dram_wdata(exe_dram_wdata), .flush(flush),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata), .mem_valid(mem_valid),
    .mem_allowin(mem_allowin), .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_ref_we(mem_ref_we), .mem_result(mem_result),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_result(fwd_result), .load_stall(load_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, alu, wd, rdata;
    logic [4:0] rd;
    logic we, re, st, sx;
    logic [1:0] sz;
    int ad, dd;
    logic [3:0] e_strb;
    logic [31:0] e_wdata, e_res;
    int e_stall;
  } vec_t;
  typedef struct {logic [31:0] pc, res; logic [4:0] rd; logic we;} res_t;
  typedef struct {logic [31:0] pc, alu, wd; logic [4:0] rd; logic we, sx; int op; logic [1:0] sz;} ins_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic we, input logic [31:0] alu,
                              input logic re, input logic st, input logic [1:0] sz, input logic sx,
                              input logic [31:0] wd, input logic [31:0] rdata, input int ad, input int dd,
                              input logic [3:0] e_strb, input logic [31:0] e_wdata, input logic [31:0] e_res,
                              input int e_stall);
    vec_t v;
    v.pc = pc; v.rd = rd; v.we = we; v.alu = alu; v.re = re; v.st = st; v.sz = sz; v.sx = sx; v.wd = wd;
    v.rdata = rdata; v.ad = ad; v.dd = dd; v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_res = e_res;
    v.e_stall = e_stall;
    return v;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [31:0] a, input logic [1:0] sz);
    int n = nbytes(sz);
    return 4'(((1 << n) - 1) << (int'(a % 4) / n * n));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [31:0] d, input logic [1:0] sz);
    int n = nbytes(sz);
    return n == 1 ? {24'd0, d[7:0]} * 32'h01010101 : n == 2 ? {16'd0, d[15:0]} * 32'h00010001 : d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] d, input logic [31:0] a, input logic [1:0] sz,
                                           input logic sx);
    int n = nbytes(sz);
    longint v;
    if (n == 4) return d;
    v = longint'((d >> (8 * (a % 4))) % (32'd1 << (8 * n)));
    if (sx && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic put(input logic [31:0] pc, input logic [4:0] rd, input logic we, input logic [31:0] alu,
                     input logic re, input logic st, input logic [1:0] sz, input logic sx, input logic [31:0] wd);
    exe_pc = pc; exe_rd = rd; exe_ref_we = we; exe_alu_result = alu; exe_dram_re = re; exe_dram_we = st;
    exe_mem_size = sz; exe_mem_sext = sx; exe_dram_wdata = wd;
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0, rq = 0, wc = 0, st = 0;
    logic ph = 1'b0;
    @(posedge clk); #1;
    put(v.pc, v.rd, v.we, v.alu, v.re, v.st, v.sz, v.sx, v.wd);
    exe_valid = 1'b1;
    @(negedge clk);
    chk("vec_allowin", exe_allowin, 1);
    @(posedge clk); #1;
    exe_valid = 1'b0;
    while (!mem_valid && n < 40) begin
      data_sram_rdata = v.rdata;
      data_sram_addr_ok = data_sram_req && rq == v.ad;
      data_sram_data_ok = ph && wc == v.dd;
      @(negedge clk);
      if (load_stall) st++;
      chk("vec_req", data_sram_req, !ph);
      if (data_sram_req) begin
        chk("vec_addr", data_sram_addr, v.alu);
        chk("vec_wr", data_sram_wr, v.st);
        chk("vec_wstrb", data_sram_wstrb, v.e_strb);
        if (v.st) chk("vec_wdata", data_sram_wdata, v.e_wdata);
        rq++;
      end
      if (ph) wc++;
      if (data_sram_addr_ok) ph = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    chk("vec_latency", n, (v.re || v.st) ? v.ad + v.dd + 2 : 0);
    @(negedge clk);
    chk("vec_mem_valid", mem_valid, 1);
    chk("vec_mem_pc", mem_pc, v.pc);
    chk("vec_mem_rd", mem_rd, v.rd);
    chk("vec_result", mem_result, v.e_res);
    chk("vec_fwd_valid", fwd_valid, v.we);
    chk("vec_fwd_rd", fwd_rd, v.rd);
    chk("vec_fwd_result", fwd_result, v.e_res);
    chk("vec_stall_cycles", st, v.e_stall);
  endtask

  function automatic ins_t rand_ins();
    ins_t i;
    i.op = int'($urandom % 3);
    i.sz = 2'($urandom % 4);
    i.alu = $urandom;
    if (i.op != 0) i.alu = i.alu & ~32'(nbytes(i.sz) - 1);
    i.pc = $urandom & ~32'd3;
    i.rd = 5'($urandom);
    i.we = 1'($urandom);
    i.sx = 1'($urandom);
    i.wd = $urandom;
    return i;
  endfunction

  vec_t tv[$];
  res_t q[$];
  ins_t nx, cur;
  logic acc, ea, rq_pend, outst, ld_busy;
  logic [31:0] rq_addr, rq_wd;
  logic [3:0] rq_strb;
  logic rq_wr;

  initial begin
    rst = 1'b1; flush = 1'b0; exe_valid = 1'b0; mem_allowin = 1'b1;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv.push_back(mk(32'h1c000000, 4, 1, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 32'h55, 0));
    tv.push_back(mk(32'h1c000004, 5, 1, 32'h103, 1, 0, 0, 1, 0, 32'h80112233, 0, 1, 4'h0, 0, 32'hffffff80, 3));
    tv.push_back(mk(32'h1c000008, 6, 1, 32'h103, 1, 0, 0, 0, 0, 32'h80112233, 2, 0, 4'h0, 0, 32'h00000080, 4));
    tv.push_back(mk(32'h1c00000c, 7, 1, 32'h100, 1, 0, 0, 1, 0, 32'h80112233, 1, 1, 4'h0, 0, 32'h00000033, 4));
    tv.push_back(mk(32'h1c000010, 8, 1, 32'h102, 1, 0, 1, 1, 0, 32'h80112233, 0, 0, 4'h0, 0, 32'hffff8011, 2));
    tv.push_back(mk(32'h1c000014, 9, 1, 32'h200, 1, 0, 1, 0, 0, 32'h1234f00d, 0, 2, 4'h0, 0, 32'h0000f00d, 4));
    tv.push_back(mk(32'h1c000018, 10, 1, 32'h104, 1, 0, 2, 1, 0, 32'hdeadbeef, 1, 1, 4'h0, 0, 32'hdeadbeef, 4));
    tv.push_back(mk(32'h1c00001c, 11, 1, 32'h108, 1, 0, 3, 1, 0, 32'h01020304, 0, 0, 4'h0, 0, 32'h01020304, 2));
    tv.push_back(mk(32'h1c000020, 0, 0, 32'h102, 0, 1, 1, 0, 32'h0000abcd, 0, 2, 1, 4'hc, 32'habcdabcd, 32'h102, 0));
    tv.push_back(mk(32'h1c000024, 0, 0, 32'h101, 0, 1, 0, 0, 32'h12345678, 0, 0, 0, 4'h2, 32'h78787878, 32'h101, 0));
    tv.push_back(mk(32'h1c000028, 0, 0, 32'h10c, 0, 1, 2, 0, 32'hcafef00d, 0, 1, 2, 4'hf, 32'hcafef00d, 32'h10c, 0));
    tv.push_back(mk(32'h1c00002c, 0, 0, 32'h100, 0, 1, 1, 0, 32'h9999beef, 0, 0, 0, 4'h3, 32'hbeefbeef, 32'h100, 0));
    tv.push_back(mk(32'h1c000030, 0, 0, 32'h203, 0, 1, 0, 0, 32'h000000aa, 0, 1, 0, 4'h8, 32'haaaaaaaa, 32'h203, 0));
    tv.push_back(mk(32'h1c000034, 0, 0, 32'h110, 0, 1, 3, 0, 32'h13579bdf, 0, 0, 1, 4'hf, 32'h13579bdf, 32'h110, 0));
    tv.push_back(mk(32'h1c000038, 0, 0, 32'hffffffff, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 32'hffffffff, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_pc", mem_pc, 32'h1bfffffc);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_allowin", exe_allowin, 0);
    chk("rst_req", data_sram_req, 0);
    chk("rst_wstrb", data_sram_wstrb, 0);
    chk("rst_result", mem_result, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_stall", load_stall, 0);
    rst = 1'b0;

    foreach (tv[i]) run_vec(tv[i]);

    // backpressure in DONE, then back-to-back accept on release
    @(posedge clk); #1;
    put(32'h1c0000a0, 12, 1, 32'h1111, 0, 0, 0, 0, 0);
    exe_valid = 1'b1; mem_allowin = 1'b0;
    @(posedge clk); #1;
    put(32'h1c0000a4, 13, 1, 32'h2222, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_mem_valid", mem_valid, 1);
      chk("bp_mem_pc", mem_pc, 32'h1c0000a0);
      chk("bp_result", mem_result, 32'h1111);
      chk("bp_allowin", exe_allowin, 0);
      @(posedge clk); #1;
    end
    mem_allowin = 1'b1;
    @(negedge clk);
    chk("bp_release_allowin", exe_allowin, 1);
    @(posedge clk); #1;
    exe_valid = 1'b0;
    chk("b2b_mem_valid", mem_valid, 1);
    chk("b2b_mem_pc", mem_pc, 32'h1c0000a4);
    chk("b2b_result", mem_result, 32'h2222);

    // flush in WAIT: the owed data_ok is swallowed before the next load may issue
    @(posedge clk); #1;
    put(32'h1c0000b0, 14, 1, 32'h300, 1, 0, 2, 0, 0);
    exe_valid = 1'b1;
    @(posedge clk); #1;
    exe_valid = 1'b0;
    chk("fw_req", data_sram_req, 1);
    data_sram_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0;
    flush = 1'b1;
    put(32'h1c0000b4, 9, 1, 32'h304, 1, 0, 2, 0, 0);
    exe_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_sram_data_ok = i == 2;
      data_sram_rdata = 32'hbad0bad0;
      @(negedge clk);
      chk("fw_cancel_req", data_sram_req, 0);
      chk("fw_cancel_valid", mem_valid, 0);
      chk("fw_cancel_allowin", exe_allowin, 0);
      chk("fw_cancel_stall", load_stall, 0);
      @(posedge clk); #1;
    end
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    chk("fw_after_allowin", exe_allowin, 1);
    chk("fw_after_valid", mem_valid, 0);
    @(posedge clk); #1;
    exe_valid = 1'b0;
    chk("fw_new_req", data_sram_req, 1);
    chk("fw_new_addr", data_sram_addr, 32'h304);
    chk("fw_new_stall", load_stall, 1);
    data_sram_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h600df00d;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    chk("fw_new_valid", mem_valid, 1);
    chk("fw_new_result", mem_result, 32'h600df00d);
    chk("fw_new_pc", mem_pc, 32'h1c0000b4);
    chk("fw_new_rd", mem_rd, 9);

    // flush in REQ before addr_ok: plain drop, no cancel
    @(posedge clk); #1;
    put(32'h1c0000c0, 3, 1, 32'h400, 1, 0, 2, 0, 0);
    exe_valid = 1'b1;
    @(posedge clk); #1;
    exe_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fr_req", data_sram_req, 0);
    chk("fr_stall", load_stall, 0);
    chk("fr_allowin", exe_allowin, 1);
    chk("fr_valid", mem_valid, 0);

    // flush in the accept cycle wins; flush in DONE empties the stage
    put(32'h1c0000d0, 2, 1, 32'h77, 0, 0, 0, 0, 0);
    exe_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fa_no_capture", mem_valid, 0);
    mem_allowin = 1'b0;
    @(posedge clk); #1;
    exe_valid = 1'b0;
    chk("fd_valid", mem_valid, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; mem_allowin = 1'b1;
    chk("fd_killed", mem_valid, 0);

    // randomized run against the scoreboard
    q.delete();
    rq_pend = 1'b0; outst = 1'b0; ld_busy = 1'b0; acc = 1'b1;
    rq_addr = 0; rq_wd = 0; rq_strb = 0; rq_wr = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (acc || !exe_valid) begin
        nx = rand_ins();
        put(nx.pc, nx.rd, nx.we, nx.alu, nx.op == 1, nx.op == 2, nx.sz, nx.sx, nx.wd);
        exe_valid = $urandom % 4 != 0;
      end
      mem_allowin = $urandom % 4 != 0;
      data_sram_addr_ok = data_sram_req && ($urandom % 2 == 0);
      data_sram_data_ok = outst && ($urandom % 3 == 0);
      data_sram_rdata = $urandom;
      @(negedge clk);
      ea = q.size() != 0 ? mem_allowin : !rq_pend && !outst;
      chk("rnd_allowin", exe_allowin, ea);
      chk("rnd_mem_valid", mem_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rnd_mem_pc", mem_pc, q[0].pc);
        chk("rnd_mem_rd", mem_rd, q[0].rd);
        chk("rnd_result", mem_result, q[0].res);
        chk("rnd_fwd_valid", fwd_valid, q[0].we);
        chk("rnd_fwd_result", fwd_result, q[0].res);
      end
      chk("rnd_req", data_sram_req, rq_pend);
      if (rq_pend) begin
        chk("rnd_addr", data_sram_addr, rq_addr);
        chk("rnd_wr", data_sram_wr, rq_wr);
        chk("rnd_wstrb", data_sram_wstrb, rq_strb);
        if (rq_wr) chk("rnd_wdata", data_sram_wdata, rq_wd);
      end
      chk("rnd_stall", load_stall, ld_busy);
      if (q.size() != 0 && mem_allowin) void'(q.pop_front());
      if (data_sram_data_ok) begin
        outst = 1'b0; ld_busy = 1'b0;
        q.push_back('{cur.pc, cur.op == 1 ? exp_load(data_sram_rdata, cur.alu, cur.sz, cur.sx) : cur.alu, cur.rd, cur.we});
      end
      if (rq_pend && data_sram_addr_ok) begin
        rq_pend = 1'b0; outst = 1'b1;
      end
      acc = exe_valid && ea;
      if (acc) begin
        cur = nx;
        if (cur.op == 0) q.push_back('{cur.pc, cur.alu, cur.rd, cur.we});
        else begin
          rq_pend = 1'b1; rq_addr = cur.alu; rq_wr = cur.op == 2;
          rq_strb = cur.op == 2 ? exp_strb(cur.alu, cur.sz) : 4'h0;
          rq_wd = exp_wd(cur.wd, cur.sz);
          ld_busy = cur.op == 1;
        end
      end
    end

    // async reset while a load waits for data_ok
    @(posedge clk); #1;
    exe_valid = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    put(32'h1c0000e0, 6, 1, 32'h500, 1, 0, 2, 0, 0);
    exe_valid = 1'b1;
    @(posedge clk); #1;
    exe_valid = 1'b0;
    data_sram_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0;
    chk("ar_wait_stall", load_stall, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_mem_pc", mem_pc, 32'h1bfffffc);
    chk("ar_stall", load_stall, 0);
    chk("ar_req", data_sram_req, 0);
    chk("ar_valid", mem_valid, 0);
    chk("ar_allowin", exe_allowin, 0);
    chk("ar_result", mem_result, 0);
    chk("ar_addr", data_sram_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
